// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and Tnew helper for stage registers and hazard unit
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [4:0]  GRF_ZERO       = 5'd0;
  localparam int          TNEW_W_DEFAULT = 3;
  // Widest Tnew field the helper supports; callers cast to their own width.
  localparam int          TNEW_MAX_W     = 8;

  // Count Tnew down by one stage, clamping at zero so a ready value never wraps to "far".
  function automatic logic [TNEW_MAX_W-1:0] tnew_sat_dec(input logic [TNEW_MAX_W-1:0] tnew);
    return (tnew == '0) ? '0 : tnew - TNEW_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic MIPS inter-stage register with stall, flush, valid and Tnew countdown (optional stats: PIPE_STAGE_STATS_EN)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int TNEW_W    = TNEW_W_DEFAULT,
  parameter int TNEW_DEC  = 1,
  parameter int FLUSH_PC  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_d,
  input  logic [31:0]          pc_d,
  input  logic [31:0]          instr_d,
  input  logic                 rf_we_d,
  input  logic [4:0]           a3_d,
  input  logic [TNEW_W-1:0]    tnew_d,
  input  logic [PAYLOAD_W-1:0] payload_d,
  output logic                 valid_q,
  output logic [31:0]          pc_q,
  output logic [31:0]          instr_q,
  output logic                 rf_we_q,
  output logic [4:0]           a3_q,
  output logic [TNEW_W-1:0]    tnew_q,
  output logic [PAYLOAD_W-1:0] payload_q
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  logic [TNEW_W-1:0] tnew_load;

  // Tnew to capture on a load; an invalid slot carries no pending write so it is ready at once.
  always_comb begin
    tnew_load = '0;
    if (valid_d) begin
      if (TNEW_DEC != 0) begin
        tnew_load = TNEW_W'(tnew_sat_dec(TNEW_MAX_W'(tnew_d)));
      end else begin
        tnew_load = tnew_d;
      end
    end
  end

  // Stage register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= NOP_INSTR;
      rf_we_q   <= 1'b0;
      a3_q      <= GRF_ZERO;
      tnew_q    <= '0;
      payload_q <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      pc_q      <= (FLUSH_PC != 0) ? pc_d : '0;
      instr_q   <= NOP_INSTR;
      rf_we_q   <= 1'b0;
      a3_q      <= GRF_ZERO;
      tnew_q    <= '0;
      payload_q <= '0;
    end else if (!stall) begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rf_we_q   <= valid_d & rf_we_d;
      a3_q      <= valid_d ? a3_d : GRF_ZERO;
      tnew_q    <= tnew_load;
      payload_q <= payload_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Performance counters: held cycles and inserted bubbles, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && !flush) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush || (!stall && !valid_d)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
